// File: rtl/decoder_3.sv
// decoder_3: 3-to-8 one-hot decoder with a combinational primary output,
// a registered shadow copy, a change strobe, and optional per-line hit
// counters enabled by defining DECODER_3_STATS_EN.
module decoder_3 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         in,
  output logic [7:0]         out,
  output logic [7:0]         out_q,
  output logic               changed,
  output logic [8*CNT_W-1:0] hit_cnt
);

  logic [2:0] in_q;
  logic       primed;

  // Combinational decode. The equality compare propagates X/Z on in to out
  // in simulation, and it does not depend on clk or reset.
  always_comb begin
    out = '0;
    for (int i = 0; i < 8; i++) begin
      out[i] = (in == 3'(i));
    end
  end

  // Shadow stage: registered one-hot plus change detection against the last
  // sample. primed masks the first sample after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      changed <= 1'b0;
      in_q    <= '0;
      primed  <= 1'b0;
    end else begin
      out_q   <= out;
      changed <= primed && (in != in_q);
      in_q    <= in;
      primed  <= 1'b1;
    end
  end

`ifdef DECODER_3_STATS_EN
  logic [CNT_W-1:0] cnt_r [8];

  // Per-line saturating hit counters. Only the selected line advances, and
  // it holds once it reaches all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (out[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_hit
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_3.sv
// Bench for decoder_3: combinational decode with the clock idle, then the
// registered path, change strobe, async reset and hit counters against a
// scoreboard fed from an independent reference model.
module tb_decoder_3;

  localparam int CNT_W = 2;

  logic               clk;
  logic               reset;
  logic [2:0]         in;
  logic [7:0]         out;
  logic [7:0]         out_q;
  logic               changed;
  logic [8*CNT_W-1:0] hit_cnt;

  int tests = 0;
  int fails = 0;
  bit run_clk = 0;

  typedef struct {
    logic [7:0]         out_q;
    logic               changed;
    logic [8*CNT_W-1:0] hit_cnt;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [2:0]       m_prev;
  bit               m_primed;
  logic [CNT_W-1:0] m_cnt [8];

  decoder_3 #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .out     (out),
    .out_q   (out_q),
    .changed (changed),
    .hit_cnt (hit_cnt)
  );

  // Clock stays undriven until the combinational checks are complete.
  initial begin
    wait (run_clk);
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input logic [2:0] v);
    logic [7:0] r;
    r = 8'h00;
    r[v] = 1'b1;
    return r;
  endfunction

  function automatic logic [8*CNT_W-1:0] pack_cnt();
    logic [8*CNT_W-1:0] r;
    r = '0;
`ifdef DECODER_3_STATS_EN
    for (int i = 0; i < 8; i++) r[i*CNT_W +: CNT_W] = m_cnt[i];
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_prev   = 3'b000;
    m_primed = 1'b0;
    for (int i = 0; i < 8; i++) m_cnt[i] = '0;
  endtask

  // Drive one code, predict the post-edge state, clock once and compare.
  task automatic step(input logic [2:0] v, input string tag);
    exp_t e;
    exp_t g;
    in = v;
    #1;
    check({tag, "_out"}, 32'(out), 32'(onehot(v)));
    e.out_q   = onehot(v);
    e.changed = m_primed && (v != m_prev);
    m_prev    = v;
    m_primed  = 1'b1;
    if (m_cnt[v] != {CNT_W{1'b1}}) m_cnt[v] = m_cnt[v] + CNT_W'(1);
    e.hit_cnt = pack_cnt();
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, "_out_q"}, 32'(out_q), 32'(g.out_q));
    check({tag, "_changed"}, 32'(changed), 32'(g.changed));
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(g.hit_cnt));
  endtask

  initial begin
    logic [2:0] codes [5];
    codes = '{3'b010, 3'b101, 3'b111, 3'b000, 3'b011};

    // combinational decode with clk and reset untouched
    for (int i = 0; i < 5; i++) begin
      in = codes[i];
      #10;
      check("comb_decode", 32'(out), 32'(onehot(codes[i])));
    end

    // reset
    reset = 1'b1;
    run_clk = 1;
    #12;
    model_reset();
    check("rst_out_q", 32'(out_q), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_out_q", 32'(out_q), 32'h0);
    reset = 1'b0;

    // registered path and change strobe
    step(3'b011, "first");
    step(3'b000, "chg");
    step(3'b000, "hold");
    step(3'b110, "chg2");
    step(3'b111, "chg3");
    check("pre_async_out_q", 32'(out_q), 32'h80);

    // async reset with no clock edge
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_out_q", 32'(out_q), 32'h0);
    check("async_changed", 32'(changed), 32'h0);
    check("async_hit_cnt", 32'(hit_cnt), 32'h0);
    check("async_out", 32'(out), 32'(onehot(3'b111)));
    in = 3'b001;
    #1;
    check("async_out_track", 32'(out), 32'h02);
    @(posedge clk);
    #1;
    check("async_hold_out_q", 32'(out_q), 32'h0);
    reset = 1'b0;

    // first sample after reset differs from pre-reset code: no pulse
    step(3'b101, "post_rst_first");
    step(3'b101, "post_rst_hold");

    // hold line 4 past counter saturation
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(3'b100, "sat");
`ifdef DECODER_3_STATS_EN
    check("sat_line4", 32'(hit_cnt), 32'(16'h0300));
`else
    check("stats_off_zero", 32'(hit_cnt), 32'h0);
`endif

    // mixed traffic
    step(3'b001, "mix1");
    step(3'b001, "mix2");
    step(3'b010, "mix3");
    step(3'b100, "mix4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
